azimuth_decoder: RTL

//  Receiver side of the radar azimuth interface: takes raw ARP/ACP lines from the

---
 rtl/azimuth_decoder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/azimuth_decoder.sv
// -----------------------------------------------------------------------------
// azimuth_decoder
//
// Receiver side of the radar azimuth interface. Recovers the antenna azimuth
// count from the raw ARP/ACP lines, measures the ACP period and reports
// link-health problems through sticky flags.
//
// Ports
//   clk          in   1      system clock (50 MHz nominal)
//   rst          in   1      asynchronous active-low reset
//   acp_in       in   1      Azimuth Change Pulse, asynchronous to clk
//   arp_in       in   1      Azimuth Reset Pulse, asynchronous, high only with ACP
//   err_clr      in   1      one-cycle pulse clearing rev_err and acp_timeout
//   azimuth      out  AZ_W   current azimuth count, 0..ACP_PER_REV-1
//   az_valid     out  1      high while locked to the ARP reference
//   acp_strobe   out  1      one-cycle pulse per accepted ACP rising edge
//   rev_strobe   out  1      one-cycle pulse per ARP-qualified ACP edge
//   acp_period   out  PER_W  clk cycles between the last two ACP edges
//   rev_err      out  1      sticky: ARP arrived early or went missing
//   acp_timeout  out  1      sticky: no ACP edge for TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module azimuth_decoder #(
    parameter int ACP_PER_REV = 4096,
    parameter int AZ_W        = 12,
    parameter int SYNC_STAGES = 2,
    parameter int PER_W       = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acp_in,
    input  logic             arp_in,
    input  logic             err_clr,
    output logic [AZ_W-1:0]  azimuth,
    output logic             az_valid,
    output logic             acp_strobe,
    output logic             rev_strobe,
    output logic [PER_W-1:0] acp_period,
    output logic             rev_err,
    output logic             acp_timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [AZ_W-1:0]  AZ_MAX      = AZ_W'(ACP_PER_REV - 1);
    localparam logic [PER_W-1:0] PER_MAX     = {PER_W{1'b1}};
    localparam logic [TO_W-1:0]  IDLE_LAST_S = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]  IDLE_FULL_S = TO_W'(TIMEOUT_CYC);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // synchronizers and edge detector
    logic [SYNC_STAGES-1:0] acp_sync_r;
    logic [SYNC_STAGES-1:0] arp_sync_r;
    logic                   acp_prev_r;
    logic                   edge_s;
    logic                   qual_s;

    // state and counters
    state_t                 state_r;
    state_t                 state_next_s;
    logic [AZ_W-1:0]        az_r;
    logic [AZ_W-1:0]        az_next_s;
    logic [TO_W-1:0]        idle_cnt_r;
    logic [TO_W-1:0]        idle_next_s;
    logic [PER_W-1:0]       per_cnt_r;
    logic [PER_W-1:0]       per_cnt_next_s;
    logic                   prev_valid_r;
    logic                   prev_valid_next_s;

    // registered outputs
    logic                   az_valid_r;
    logic                   acp_strobe_r;
    logic                   rev_strobe_r;
    logic [PER_W-1:0]       acp_period_r;
    logic                   rev_err_r;
    logic                   acp_timeout_r;

    logic                   acp_strobe_next_s;
    logic                   rev_strobe_next_s;
    logic [PER_W-1:0]       period_next_s;
    logic                   rev_err_set_s;
    logic                   timeout_set_s;
    logic                   rev_err_next_s;
    logic                   timeout_next_s;

    // Edge of the synchronized ACP; ARP qualifies only in the same cycle.
    assign edge_s = acp_sync_r[SYNC_STAGES-1] & ~acp_prev_r;
    assign qual_s = edge_s & arp_sync_r[SYNC_STAGES-1];

    // Next-state, azimuth tracking, period measurement and timeout detection.
    always_comb begin
        state_next_s      = state_r;
        az_next_s         = az_r;
        idle_next_s       = idle_cnt_r;
        per_cnt_next_s    = per_cnt_r;
        prev_valid_next_s = prev_valid_r;
        period_next_s     = acp_period_r;
        acp_strobe_next_s = 1'b0;
        rev_strobe_next_s = 1'b0;
        rev_err_set_s     = 1'b0;
        timeout_set_s     = 1'b0;

        if (edge_s) begin
            acp_strobe_next_s = 1'b1;
            idle_next_s       = {TO_W{1'b0}};
            per_cnt_next_s    = PER_W'(1);
            prev_valid_next_s = 1'b1;
            // Without a valid prior edge the running count is meaningless.
            if (prev_valid_r) begin
                period_next_s = per_cnt_r;
            end else begin
                period_next_s = acp_period_r;
            end

            case (state_r)
                ST_SEARCH: begin
                    if (qual_s) begin
                        az_next_s         = {AZ_W{1'b0}};
                        rev_strobe_next_s = 1'b1;
                        state_next_s      = ST_LOCKED;
                    end else begin
                        az_next_s = az_r;
                    end
                end
                ST_LOCKED: begin
                    if (qual_s) begin
                        az_next_s         = {AZ_W{1'b0}};
                        rev_strobe_next_s = 1'b1;
                        // ARP anywhere but the last ACP of a revolution is early.
                        rev_err_set_s     = (az_r != AZ_MAX);
                    end else if (az_r == AZ_MAX) begin
                        // Wrapping on our own means the ARP went missing.
                        az_next_s     = {AZ_W{1'b0}};
                        rev_err_set_s = 1'b1;
                    end else begin
                        az_next_s = az_r + AZ_W'(1);
                    end
                end
                default: begin
                    state_next_s = ST_SEARCH;
                    az_next_s    = {AZ_W{1'b0}};
                end
            endcase
        end else begin
            if (per_cnt_r == PER_MAX) begin
                per_cnt_next_s = per_cnt_r;
            end else begin
                per_cnt_next_s = per_cnt_r + PER_W'(1);
            end

            // Counter parks at TIMEOUT_CYC so the loss event fires only once.
            if (idle_cnt_r == IDLE_LAST_S) begin
                idle_next_s       = IDLE_FULL_S;
                timeout_set_s     = 1'b1;
                state_next_s      = ST_SEARCH;
                prev_valid_next_s = 1'b0;
            end else if (idle_cnt_r == IDLE_FULL_S) begin
                idle_next_s = idle_cnt_r;
            end else begin
                idle_next_s = idle_cnt_r + TO_W'(1);
            end
        end

        // Sticky flags: a new event in the clear cycle must not be lost.
        rev_err_next_s = rev_err_set_s | (rev_err_r & ~err_clr);
        timeout_next_s = timeout_set_s | (acp_timeout_r & ~err_clr);
    end

    // All state, synchronizers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acp_sync_r    <= {SYNC_STAGES{1'b0}};
            arp_sync_r    <= {SYNC_STAGES{1'b0}};
            acp_prev_r    <= 1'b0;
            state_r       <= ST_SEARCH;
            az_r          <= {AZ_W{1'b0}};
            idle_cnt_r    <= {TO_W{1'b0}};
            per_cnt_r     <= {PER_W{1'b0}};
            prev_valid_r  <= 1'b0;
            az_valid_r    <= 1'b0;
            acp_strobe_r  <= 1'b0;
            rev_strobe_r  <= 1'b0;
            acp_period_r  <= {PER_W{1'b0}};
            rev_err_r     <= 1'b0;
            acp_timeout_r <= 1'b0;
        end else begin
            acp_sync_r    <= {acp_sync_r[SYNC_STAGES-2:0], acp_in};
            arp_sync_r    <= {arp_sync_r[SYNC_STAGES-2:0], arp_in};
            acp_prev_r    <= acp_sync_r[SYNC_STAGES-1];
            state_r       <= state_next_s;
            az_r          <= az_next_s;
            idle_cnt_r    <= idle_next_s;
            per_cnt_r     <= per_cnt_next_s;
            prev_valid_r  <= prev_valid_next_s;
            az_valid_r    <= (state_next_s == ST_LOCKED);
            acp_strobe_r  <= acp_strobe_next_s;
            rev_strobe_r  <= rev_strobe_next_s;
            acp_period_r  <= period_next_s;
            rev_err_r     <= rev_err_next_s;
            acp_timeout_r <= timeout_next_s;
        end
    end

    assign azimuth     = az_r;
    assign az_valid    = az_valid_r;
    assign acp_strobe  = acp_strobe_r;
    assign rev_strobe  = rev_strobe_r;
    assign acp_period  = acp_period_r;
    assign rev_err     = rev_err_r;
    assign acp_timeout = acp_timeout_r;

endmodule
